// File: rtl/id_pkg.sv
// Shared decode constants and the control bundle carried in the ID/EX register.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       use_imm;
    logic       illegal;
    logic [5:0] alu_fn;
  } ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decode: control flags, destination,
// operand usage and extended immediate.
module id_decoder
  import id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [DATA_W-1:0] instr,
  output ctrl_t             ctrl,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] dest,
  output logic              uses_rs,
  output logic              uses_rt
);

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic              sext;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[16 +: ADDR_W];
  assign rd    = instr[11 +: ADDR_W];

  always_comb begin
    ctrl    = '0;
    dest    = '0;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    sext    = 1'b1;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        dest        = rd;
        ctrl.reg_wr = 1'b1;
        ctrl.alu_fn = funct;
        uses_rt     = 1'b1;
      end
      (op == OP_LW): begin
        dest         = rt;
        ctrl.reg_wr  = 1'b1;
        ctrl.mem_rd  = 1'b1;
        ctrl.use_imm = 1'b1;
        ctrl.alu_fn  = FN_ADD;
      end
      (op == OP_SW): begin
        ctrl.mem_wr  = 1'b1;
        ctrl.use_imm = 1'b1;
        ctrl.alu_fn  = FN_ADD;
        uses_rt      = 1'b1;
      end
      (op == OP_ADDI): begin
        dest         = rt;
        ctrl.reg_wr  = 1'b1;
        ctrl.use_imm = 1'b1;
        ctrl.alu_fn  = FN_ADD;
      end
      (op == OP_ANDI): begin
        dest         = rt;
        ctrl.reg_wr  = 1'b1;
        ctrl.use_imm = 1'b1;
        ctrl.alu_fn  = FN_AND;
        sext         = 1'b0;
      end
      (op == OP_ORI): begin
        dest         = rt;
        ctrl.reg_wr  = 1'b1;
        ctrl.use_imm = 1'b1;
        ctrl.alu_fn  = FN_OR;
        sext         = 1'b0;
      end
      (op == OP_BEQ): begin
        ctrl.branch = 1'b1;
        ctrl.alu_fn = FN_SUB;
        uses_rt     = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
        uses_rs      = 1'b0;
      end
    endcase
    // r0 is hardwired, so writes to it are suppressed here
    if (dest == '0) ctrl.reg_wr = 1'b0;
  end

  assign imm = sext ? {{(DATA_W-16){instr[15]}}, instr[15:0]}
                    : {{(DATA_W-16){1'b0}}, instr[15:0]};

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: regfile read, WB bypass, load-use
// stall and the ID/EX pipeline register.
module id_stage
  import id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic [ADDR_W-1:0] Ard1,
  output logic [ADDR_W-1:0] Ard2,
  input  logic [DATA_W-1:0] Dout1,
  input  logic [DATA_W-1:0] Dout2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_reg_wr,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_branch,
  output logic              out_use_imm,
  output logic [5:0]        out_alu_fn,
  output logic              out_illegal
);

  logic [ADDR_W-1:0] rs, rt;
  ctrl_t             dec_ctrl;
  logic [DATA_W-1:0] dec_imm;
  logic [ADDR_W-1:0] dec_dest;
  logic              uses_rs, uses_rt;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              hazard, adv, load;

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d;
  logic [DATA_W-1:0] rt_val_q, rt_val_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  ctrl_t             ctrl_q, ctrl_d;

  assign rs   = in_instr[21 +: ADDR_W];
  assign rt   = in_instr[16 +: ADDR_W];
  assign Ard1 = rs;
  assign Ard2 = rt;

  id_decoder #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dec (
    .instr  (in_instr),
    .ctrl   (dec_ctrl),
    .imm    (dec_imm),
    .dest   (dec_dest),
    .uses_rs(uses_rs),
    .uses_rt(uses_rt)
  );

  function automatic logic [DATA_W-1:0] opnd(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] rf,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (a == '0)            return '0;
    if (we && (wa == a))    return wd;
    return rf;
  endfunction

  assign rs_val = opnd(rs, Dout1, wb_en, wb_addr, wb_data);
  assign rt_val = opnd(rt, Dout2, wb_en, wb_addr, wb_data);

  assign hazard = valid_q && ctrl_q.mem_rd && (dest_q != '0) &&
                  ((uses_rs && (rs == dest_q)) ||
                   (uses_rt && (rt == dest_q)));
  assign adv      = !valid_q || out_ready;
  assign load     = adv && in_valid && !hazard;
  assign in_ready = Rst_n && (flush || (adv && !hazard));

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    rs_val_d = rs_val_q;
    rt_val_d = rt_val_q;
    imm_d    = imm_q;
    dest_d   = dest_q;
    ctrl_d   = ctrl_q;
    if (flush || (adv && !load)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d  = 1'b1;
      pc_d     = in_pc;
      rs_val_d = rs_val;
      rt_val_d = rt_val;
      imm_d    = dec_imm;
      dest_d   = dec_dest;
      ctrl_d   = dec_ctrl;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      imm_q    <= '0;
      dest_q   <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rs_val_q <= rs_val_d;
      rt_val_q <= rt_val_d;
      imm_q    <= imm_d;
      dest_q   <= dest_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_rs_val  = rs_val_q;
  assign out_rt_val  = rt_val_q;
  assign out_imm     = imm_q;
  assign out_dest    = dest_q;
  assign out_reg_wr  = ctrl_q.reg_wr;
  assign out_mem_rd  = ctrl_q.mem_rd;
  assign out_mem_wr  = ctrl_q.mem_wr;
  assign out_branch  = ctrl_q.branch;
  assign out_use_imm = ctrl_q.use_imm;
  assign out_alu_fn  = ctrl_q.alu_fn;
  assign out_illegal = ctrl_q.illegal;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage that sits directly upstream of regfile.
- Accepts fetched instructions over a valid/ready handshake and drives regfile read addresses Ard1/Ard2.
- Samples Dout1/Dout2, with write-back bypass, into a single ID/EX pipeline register, together with decoded control and extended immediate.
- Detects load-use hazards and inserts one bubble per hazard.

Parameters:
- DATA_W, 32, datapath / instruction width
- ADDR_W, 5, register address width
- PC_W, 32, program counter width

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  DATA_W  instruction word
- in_pc  in  PC_W  instruction address
- flush  in  1  kill ID/EX contents and the incoming instruction
- Ard1  out  ADDR_W  regfile read address 1 (rs)
- Ard2  out  ADDR_W  regfile read address 2 (rt)
- Dout1  in  DATA_W  regfile read data 1
- Dout2  in  DATA_W  regfile read data 2
- wb_en  in  1  write-back enable (same net as regfile WrEn)
- wb_addr  in  ADDR_W  write-back address (same net as Awr)
- wb_data  in  DATA_W  write-back data (same net as Din)
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  EX consumes the ID/EX register this cycle
- out_pc  out  PC_W  captured pc
- out_rs_val  out  DATA_W  operand A
- out_rt_val  out  DATA_W  operand B
- out_imm  out  DATA_W  extended immediate
- out_dest  out  ADDR_W  destination register
- out_reg_wr  out  1  instruction writes a register
- out_mem_rd  out  1  load
- out_mem_wr  out  1  store
- out_branch  out  1  BEQ
- out_use_imm  out  1  ALU B operand is out_imm
- out_alu_fn  out  6  funct field for R-type, fixed code otherwise
- out_illegal  out  1  undecodable opcode

Behaviour:
- Fields: opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], funct = [5:0].
- Ard1 = rs and Ard2 = rt, combinational from in_instr every cycle, regardless of in_valid.
- Decode:
  - 000000 R-type: dest = rd, reg_wr = 1, alu_fn = funct.
  - 100011 LW: dest = rt, sign-ext, mem_rd = 1, use_imm = 1, alu_fn = 100000.
  - 101011 SW: mem_wr = 1, sign-ext, use_imm = 1, reg_wr = 0, reads rt.
  - 001000 ADDI: sign-ext, alu_fn = 100000.
  - 001100 ANDI: zero-ext, alu_fn = 100100.
  - 001101 ORI: zero-ext, alu_fn = 100101.
  - 000100 BEQ: branch = 1, reg_wr = 0, sign-ext, alu_fn = 100010.
  - Any other opcode: illegal = 1, all write/mem/branch flags 0.
- reg_wr is forced 0 whenever dest == 0.
- Operand select (rs_val; rt_val identical with rt/Dout2):
  - rs == 0 gives 0.
  - Otherwise, wb_en && wb_addr == rs gives wb_data.
  - Otherwise Dout1.
- Rs use: R-type, LW, SW, ADDI, ANDI, ORI, BEQ. Rt use: R-type, SW, BEQ.
- Hazard = out_valid && out_mem_rd && out_dest != 0 && ((uses_rs && rs == out_dest) || (uses_rt && rt == out_dest)).
- adv = !out_valid || out_ready.
- in_ready = flush || (adv && !hazard).
- Register update at rising Clk:
  - flush: out_valid <= 0, incoming instruction dropped; flush has priority over everything.
  - else adv && in_valid && !hazard: load decoded instruction, out_valid <= 1.
  - else adv: out_valid <= 0 (bubble).
  - else hold all outputs.
- Latency: 1 cycle from accepted instruction to out_valid.
- Throughput: 1 instruction per cycle with no hazard.
- Load-use costs exactly one bubble. The stall is released in the cycle after EX accepts the load.
- Reset (async, Rst_n = 0): out_valid and all out_* = 0. in_ready = 0 while Rst_n = 0. Reset mid-operation discards the held instruction.
- Data fields of a bubble are don't-care; control flags of a bubble are forced 0.

Decomposition:
- Package id_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ) and ALU function codes (FN_ADD, FN_SUB, FN_AND, FN_OR).
- One sub-module, id_decoder: purely combinational opcode-to-control-flags/immediate-extend logic. Hazard, bypass and pipeline register stay in id_stage.

Test Plan:
- ADDI r3,r1,-4 (0x2023FFFC), Dout1 = 10, out_ready = 1 -> next cycle out_valid = 1, rs_val = 10, imm = 0xFFFFFFFC, dest = 3, reg_wr = 1, use_imm = 1.
- ORI r2,r0,0x8000 (0x34028000) -> imm = 0x00008000, rs_val = 0 even with Dout1 = 0xDEAD.
- Bypass: R-type rs = 5, Dout1 = 7, wb_en = 1, wb_addr = 5, wb_data = 99 -> rs_val = 99; same with wb_addr = 6 -> rs_val = 7.
- Load-use: LW r4 then ADD r6,r4,r2 back-to-back, out_ready = 1 -> in_ready = 0 for one cycle, one bubble (out_valid = 0), ADD issued the following cycle.
- Back-pressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs stable; release -> resumes with no loss or duplication.
- Flush with out_valid = 1 and in_valid = 1 -> next cycle out_valid = 0, incoming dropped. Async Rst_n pulse mid-stream -> out_valid = 0 immediately, without waiting for a clock edge.
